alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//  Parametrised, registered successor to the combinational ALU-with-control: WIDTH-bit ALU
//  with valid/ready handshakes on both sides, a registered result and a flags register.
//  Sits between the decode/control stage and writeback. Adds an optional multi-cycle
//  shift-add multiplier, so the datapath can stall on long operations.
// PARAMETERS
//  WIDTH    32   operand/result width in bits (>=4)
//  CTLW     4    ALU control code width (fixed encoding below, upper bits zero-extended)
// PORTS
//  clk        in   1      single clock, all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      a/b/ALUctl valid this cycle
//  in_ready   out  1      unit can accept an operation this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ALUctl     in   CTLW   operation select
//  out_valid  out  1      ALUOut/flags hold a completed result
//  out_ready  in   1      consumer takes result this cycle
//  ALUOut     out  WIDTH  registered result
//  zero       out  1      ALUOut == 0
//  carry      out  1      carry-out of ADD; NOT borrow of SUB/SLT; 0 otherwise
//  ovf        out  1      signed overflow of ADD/SUB; 0 otherwise
//  illegal    out  1      ALUctl was not a supported code
// BEHAVIOUR
//  - Codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0),
//    1100 NOR, 0011 XOR, 1000 MUL (low WIDTH bits of a*b, unsigned). Anything else: illegal.
//  - Handshake: transfer on in_valid&&in_ready; result consumed on out_valid&&out_ready.
//    in_valid/operands must be held stable until accepted; unit never drops a result.
//  - FSM IDLE/BUSY/DONE. in_ready = (IDLE) || (DONE && out_ready); out_valid = (DONE).
//  - Accept of single-cycle op at edge N: result/flags registered at edge N, out_valid=1
//    in cycle N+1 (latency 1). Back-to-back accept while DONE&&out_ready -> stays DONE,
//    new result replaces old in same edge (throughput 1/cycle).
//  - Accept of MUL at edge N: operands latched, cnt=WIDTH-1, go BUSY; one multiplier bit
//    per cycle; edge where cnt==0 -> DONE. out_valid in cycle N+WIDTH+1. in_ready=0 in BUSY.
//  - DONE && out_ready && !in_valid -> IDLE. DONE && !out_ready -> hold all outputs.
//  - Illegal code: single-cycle, ALUOut=0, zero=1, carry=ovf=0, illegal=1.
//  - SUB/SLT computed as a + ~b + 1 on WIDTH+1 bits; ovf = sign rule; SLT = N xor V.
//  - Reset (any state, incl. mid-MUL): state=IDLE, ALUOut=0, zero=0, carry=0, ovf=0,
//    illegal=0, out_valid=0, cnt=0; in-flight operation discarded. in_ready=1 the cycle after.
//  - Reset asserted concurrently with in_valid: reset wins, operation not accepted.
// CONFIGURATION
//  ALU_SEQ_MUL_EN defined: code 1000 is MUL as above (BUSY state and counter present).
//  Not defined: no BUSY state/multiplier logic; 1000 treated as illegal (single-cycle).
// TESTING (WIDTH=32)
//  1. a=5,b=3 AND/OR/XOR/ADD/SUB/NOR, out_ready=1 -> 1,7,6,8,2,FFFFFFF8, each 1 cycle later.
//  2. SLT a=FFFFFFFF,b=1 -> ALUOut=1; a=1,b=FFFFFFFF -> 0; SUB a=3,b=3 -> 0, zero=1, carry=1.
//  3. ADD a=7FFFFFFF,b=1 -> 80000000, ovf=1, carry=0; ADD FFFFFFFF+1 -> 0, carry=1, zero=1.
//  4. MUL a=5,b=3 (MUL_EN) -> in_ready=0 for 32 cycles, out_valid at accept+33, ALUOut=F;
//     without MUL_EN -> illegal=1, ALUOut=0 after 1 cycle.
//  5. out_ready=0 for 5 cycles after result, in_valid high -> ALUOut stable, no accept;
//     release -> second op accepted same cycle, result next cycle.
//  6. reset pulse mid-MUL (cycle 10 of BUSY) -> all outputs 0, IDLE, no stale out_valid.

Source files
------------

// File: rtl/alu_seq_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : alu_seq_unit                                                   |
// | Purpose  : Registered WIDTH-bit ALU with valid/ready handshakes on both   |
// |            sides, a registered result and a flags register. Optional      |
// |            multi-cycle shift-add multiplier (one multiplier bit/cycle).   |
// | Ports    : clk, reset (sync, active-high)                                 |
// |            in_valid/in_ready, a, b, ALUctl       - operation request      |
// |            out_valid/out_ready, ALUOut           - result handshake       |
// |            zero, carry, ovf, illegal             - result flags           |
// | Config   : define ALU_SEQ_MUL_EN to enable code 1000 (MUL) with its BUSY  |
// |            state; otherwise 1000 is reported as illegal.                  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module alu_seq_unit #(
   parameter int WIDTH = 32,
   parameter int CTLW  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [CTLW-1:0]  ALUctl,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] ALUOut,
   output logic             zero,
   output logic             carry,
   output logic             ovf,
   output logic             illegal
);

   localparam logic [CTLW-1:0] c_OP_AND = CTLW'(4'b0000);
   localparam logic [CTLW-1:0] c_OP_OR  = CTLW'(4'b0001);
   localparam logic [CTLW-1:0] c_OP_ADD = CTLW'(4'b0010);
   localparam logic [CTLW-1:0] c_OP_XOR = CTLW'(4'b0011);
   localparam logic [CTLW-1:0] c_OP_SUB = CTLW'(4'b0110);
   localparam logic [CTLW-1:0] c_OP_SLT = CTLW'(4'b0111);
   localparam logic [CTLW-1:0] c_OP_MUL = CTLW'(4'b1000);
   localparam logic [CTLW-1:0] c_OP_NOR = CTLW'(4'b1100);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_BUSY = 2'd1;
   localparam logic [1:0] c_ST_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       w_start_st;
   logic             w_accept;
   logic [WIDTH:0]   w_add, w_sub;
   logic             w_add_ovf, w_sub_ovf;
   logic [WIDTH-1:0] w_res;
   logic             w_c, w_v, w_ill, w_is_mul;
   logic [WIDTH-1:0] res_q;
   logic             zero_q, carry_q, ovf_q, ill_q;

   assign w_accept = in_valid && in_ready;

   // Both add and subtract carry out of an extra bit; subtract is a + ~b + 1,
   // so its carry is the inverse of borrow.
   assign w_add     = {1'b0, a} + {1'b0, b};
   assign w_sub     = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
   assign w_add_ovf = ~(a[WIDTH-1] ^ b[WIDTH-1]) & (w_add[WIDTH-1] ^ a[WIDTH-1]);
   assign w_sub_ovf =  (a[WIDTH-1] ^ b[WIDTH-1]) & (w_sub[WIDTH-1] ^ a[WIDTH-1]);

   // Single-cycle result and flags for the presented operation.
   always_comb begin
      w_res    = '0;
      w_c      = 1'b0;
      w_v      = 1'b0;
      w_ill    = 1'b0;
      w_is_mul = 1'b0;
      case (ALUctl)
         c_OP_AND: w_res = a & b;
         c_OP_OR:  w_res = a | b;
         c_OP_XOR: w_res = a ^ b;
         c_OP_NOR: w_res = ~(a | b);
         c_OP_ADD: begin
            w_res = w_add[WIDTH-1:0];
            w_c   = w_add[WIDTH];
            w_v   = w_add_ovf;
         end
         c_OP_SUB: begin
            w_res = w_sub[WIDTH-1:0];
            w_c   = w_sub[WIDTH];
            w_v   = w_sub_ovf;
         end
         c_OP_SLT: begin
            // Signed less-than is N xor V of the subtraction.
            w_res = {{(WIDTH-1){1'b0}}, w_sub[WIDTH-1] ^ w_sub_ovf};
            w_c   = w_sub[WIDTH];
         end
`ifdef ALU_SEQ_MUL_EN
         c_OP_MUL: w_is_mul = 1'b1;
`endif
         default:  w_ill = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   localparam int c_CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_d;
   logic [c_CW-1:0]  cnt_q;

   // Shift-add step: multiplicand moves left, multiplier right, one bit/cycle.
   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else if (w_accept && w_is_mul) begin
         mcand_q  <= a;
         mplier_q <= b;
         acc_q    <= '0;
         cnt_q    <= c_CW'(WIDTH-1);
      end else if (state_q == c_ST_BUSY) begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - c_CW'(1);
         end
      end
   end

   assign w_start_st = w_is_mul ? c_ST_BUSY : c_ST_DONE;
`else
   assign w_start_st = c_ST_DONE;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= c_ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         c_ST_IDLE: if (w_accept) state_d = w_start_st;
`ifdef ALU_SEQ_MUL_EN
         c_ST_BUSY: if (cnt_q == '0) state_d = c_ST_DONE;
`endif
         c_ST_DONE: begin
            if (out_ready) begin
               state_d = w_accept ? w_start_st : c_ST_IDLE;
            end
         end
         default:   state_d = c_ST_IDLE;
      endcase
   end

   // Handshake outputs; a consumed result frees the slot in the same cycle.
   always_comb begin
      in_ready  = (state_q == c_ST_IDLE) || ((state_q == c_ST_DONE) && out_ready);
      out_valid = (state_q == c_ST_DONE);
   end

   // Result/flags register: loads only on accept (or multiplier completion),
   // so a stalled result is held untouched.
   always_ff @(posedge clk) begin
      if (reset) begin
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else if (w_accept) begin
         res_q   <= w_res;
         zero_q  <= (w_res == '0);
         carry_q <= w_c;
         ovf_q   <= w_v;
         ill_q   <= w_ill;
`ifdef ALU_SEQ_MUL_EN
      end else if ((state_q == c_ST_BUSY) && (cnt_q == '0)) begin
         res_q   <= acc_d;
         zero_q  <= (acc_d == '0);
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         ill_q   <= 1'b0;
`endif
      end
   end

   assign ALUOut  = res_q;
   assign zero    = zero_q;
   assign carry   = carry_q;
   assign ovf     = ovf_q;
   assign illegal = ill_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_alu_seq_unit                                                |
// | Purpose  : Self-checking bench for alu_seq_unit (WIDTH=32): directed      |
// |            corner steps plus randomized operations against a behavioural  |
// |            reference model. Honours ALU_SEQ_MUL_EN.                       |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_alu_seq_unit;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset, in_valid, in_ready, out_valid, out_ready;
   logic          zero, carry, ovf, illegal;
   logic [W-1:0]  a, b, ALUOut;
   logic [3:0]    ALUctl;
   logic [35:0]   obs;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [31:0] res;
      logic        z;
      logic        c;
      logic        v;
      logic        ill;
   } exp_t;

   always #5 clk = ~clk;

   assign obs = {ALUOut, zero, carry, ovf, illegal};

   alu_seq_unit #(.WIDTH(W), .CTLW(4)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .ALUctl(ALUctl),
      .out_valid(out_valid), .out_ready(out_ready),
      .ALUOut(ALUOut), .zero(zero), .carry(carry), .ovf(ovf), .illegal(illegal)
   );

   // Reference model: plain arithmetic on the operation definitions.
   function automatic exp_t model(input logic [3:0] op, input logic [31:0] x,
                                  input logic [31:0] y);
      exp_t   e;
      longint sx, sy, s;
      e  = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (op)
         4'd0:  e.res = x & y;
         4'd1:  e.res = x | y;
         4'd3:  e.res = x ^ y;
         4'd12: e.res = ~(x | y);
         4'd2: begin
            e.res = x + y;
            e.c   = (64'(x) + 64'(y)) > 64'hFFFF_FFFF;
            s     = sx + sy;
            e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd6: begin
            e.res = x - y;
            e.c   = (x >= y);
            s     = sx - sy;
            e.v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         4'd7: begin
            e.res = (sx < sy) ? 32'd1 : 32'd0;
            e.c   = (x >= y);
         end
`ifdef ALU_SEQ_MUL_EN
         4'd8:  e.res = 32'(64'(x) * 64'(y));
`endif
         default: e.ill = 1'b1;
      endcase
      e.z = (e.res == 32'd0);
      return e;
   endfunction

   function automatic bit is_long(input logic [3:0] op);
`ifdef ALU_SEQ_MUL_EN
      return op == 4'd8;
`else
      return (op == 4'd8) && 1'b0;
`endif
   endfunction

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      n_vec++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      tick();
      reset = 1'b0;
   endtask

   // One complete transaction: present, wait for accept, wait for result,
   // optional consumer stall, then drain.
   task automatic do_op(input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int stall, input string tag);
      exp_t e;
      int   t;
      bit   ok;
      e = model(op, x, y);
      ALUctl = op; a = x; b = y;
      in_valid = 1'b1;
      out_ready = (stall == 0);
      t = 0;
      while (!in_ready && t < 100) begin
         tick();
         t++;
      end
      chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      if (is_long(op)) begin
         ok = 1'b1;
         for (int k = 0; k < W; k++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b0) ok = 1'b0;
            tick();
         end
         chk({tag, " busy"}, 64'(ok), 64'd1);
      end
      chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
      chk({tag, " result"}, 64'(obs), 64'(e));
      if (stall > 0) begin
         ok = 1'b1;
         for (int k = 0; k < stall; k++) begin
            tick();
            if (obs !== 36'(e) || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
         end
         chk({tag, " stall hold"}, 64'(ok), 64'd1);
         out_ready = 1'b1;
      end
      tick();
      chk({tag, " drain"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [31:0] lit [6];
      logic [3:0]  ops [6];
      logic [3:0]  rops [8];
      logic [31:0] corner [5];
      logic [31:0] x, y;
      logic [3:0]  op;
      bit          ok;
      int          r;

      ops  = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd12};
      lit  = '{32'd1, 32'd7, 32'd6, 32'd8, 32'd2, 32'hFFFF_FFF8};
      rops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd7, 4'd12, 4'd8};
      corner = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; ALUctl = '0;
      tick(); tick();
      reset = 1'b0;
      chk("reset outputs", 64'(obs), 64'd0);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);

      // Basic logic/arith with a=5, b=3
      for (int i = 0; i < 6; i++) begin
         do_op(ops[i], 32'd5, 32'd3, 0, $sformatf("op%0d 5,3", ops[i]));
         chk($sformatf("op%0d literal", ops[i]), 64'(ALUOut), 64'(lit[i]));
      end

      // SLT / SUB / ADD flag corners
      do_op(4'd7, 32'hFFFF_FFFF, 32'd1, 0, "slt -1<1");
      chk("slt -1<1 literal", 64'(ALUOut), 64'd1);
      do_op(4'd7, 32'd1, 32'hFFFF_FFFF, 0, "slt 1<-1");
      chk("slt 1<-1 literal", 64'(ALUOut), 64'd0);
      do_op(4'd6, 32'd3, 32'd3, 0, "sub 3-3");
      chk("sub 3-3 z/c", 64'({zero, carry}), 64'b11);
      do_op(4'd2, 32'h7FFF_FFFF, 32'd1, 0, "add ovf");
      chk("add ovf literal", 64'({ALUOut, ovf, carry}), {30'd0, 32'h8000_0000, 2'b10});
      do_op(4'd2, 32'hFFFF_FFFF, 32'd1, 0, "add carry");
      chk("add carry literal", 64'({ALUOut, zero, carry}), {30'd0, 32'd0, 2'b11});

      // MUL (or illegal without the multiplier)
      do_op(4'd8, 32'd5, 32'd3, 0, "mul 5*3");
`ifdef ALU_SEQ_MUL_EN
      chk("mul literal", 64'({ALUOut, illegal}), 64'({32'hF, 1'b0}));
`else
      chk("mul illegal literal", 64'({ALUOut, zero, illegal}), 64'({32'h0, 2'b11}));
`endif
      do_op(4'd5, 32'd9, 32'd9, 1, "illegal 0101");

      // Consumer stall with next op waiting, then back-to-back accept
      ALUctl = 4'd2; a = 32'd10; b = 32'd20;
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      ALUctl = 4'd6; a = 32'd50; b = 32'd8;
      ok = 1'b1;
      for (int k = 0; k < 5; k++) begin
         if (ALUOut !== 32'd30 || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
         tick();
      end
      chk("stall hold 5", 64'(ok), 64'd1);
      out_ready = 1'b1;
      #1;
      chk("release in_ready", 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      chk("b2b second result", 64'({out_valid, ALUOut}), 64'({1'b1, 32'd42}));
      tick();
      chk("b2b drain", 64'(out_valid), 64'd0);

      // Reset while an operation is in flight
`ifdef ALU_SEQ_MUL_EN
      ALUctl = 4'd8; a = 32'd5; b = 32'd3; out_ready = 1'b1;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (9) tick();
`else
      ALUctl = 4'd2; a = 32'hFFFF_FFFF; b = 32'd1; out_ready = 1'b0;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
`endif
      do_reset();
      out_ready = 1'b1;
      chk("mid-op reset outputs", 64'({obs, out_valid, in_ready}), 64'({36'd0, 1'b0, 1'b1}));
      ok = 1'b1;
      for (int k = 0; k < W + 4; k++) begin
         if (out_valid !== 1'b0) ok = 1'b0;
         tick();
      end
      chk("no stale out_valid", 64'(ok), 64'd1);

      // Reset concurrent with in_valid: nothing accepted
      ALUctl = 4'd1; a = 32'd12; b = 32'd3;
      reset = 1'b1; in_valid = 1'b1;
      tick();
      reset = 1'b0; in_valid = 1'b0;
      tick();
      chk("reset beats in_valid", 64'({obs, out_valid, in_ready}), 64'({36'd0, 1'b0, 1'b1}));

      // Randomized operations with random consumer stalls
      for (int i = 0; i < 60; i++) begin
         r  = $urandom_range(0, 9);
         op = (r < 8) ? rops[r] : 4'($urandom);
         x  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         y  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         do_op(op, x, y, $urandom_range(0, 2), $sformatf("rnd%0d op%0d", i, op));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
